// File: rtl/pipe_decode_execute.sv
// -----------------------------------------------------------------------------
// pipe_decode_execute
//
// Decode -> execute pipeline register for the 5-stage RV32I core. It captures
// the decode-stage datapath (register read data, immediate, PC, PC+4, register
// addresses) and control fields, and presents them to the execute stage one
// cycle later.
//
// The hazard unit steers the stage with two controls. flush_e has priority
// and loads a bubble. stall_e holds the stage. With neither asserted, the
// stage loads normally. Two saturating performance counters record stalled
// and flushed cycles. cnt_clr clears them synchronously.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   stall_e, flush_e  hazard-unit hold / bubble-insert controls
//   cnt_clr           synchronous clear of stall_count and flush_count
//   *_d               decode-stage valid, control, data, PC and register fields
//   *_e               registered execute-stage copies of every *_d input
//   stall_count       edges with stall_e=1 and flush_e=0 (saturating)
//   flush_count       edges with flush_e=1 (saturating)
// -----------------------------------------------------------------------------
module pipe_decode_execute #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      stall_e,
  input  logic                      flush_e,
  input  logic                      cnt_clr,

  input  logic                      valid_d,
  input  logic                      regwrite_d,
  input  logic [1:0]                resultsrc_d,
  input  logic                      memwrite_d,
  input  logic                      jump_d,
  input  logic                      branch_d,
  input  logic                      alusrc_d,
  input  logic [ALU_CTRL_WIDTH-1:0] alucontrol_d,
  input  logic [DATA_WIDTH-1:0]     rd1_d,
  input  logic [DATA_WIDTH-1:0]     rd2_d,
  input  logic [DATA_WIDTH-1:0]     immext_d,
  input  logic [ADDRESS_WIDTH-1:0]  pc_d,
  input  logic [ADDRESS_WIDTH-1:0]  pcplus4_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,

  output logic                      valid_e,
  output logic                      regwrite_e,
  output logic [1:0]                resultsrc_e,
  output logic                      memwrite_e,
  output logic                      jump_e,
  output logic                      branch_e,
  output logic                      alusrc_e,
  output logic [ALU_CTRL_WIDTH-1:0] alucontrol_e,
  output logic [DATA_WIDTH-1:0]     rd1_e,
  output logic [DATA_WIDTH-1:0]     rd2_e,
  output logic [DATA_WIDTH-1:0]     immext_e,
  output logic [ADDRESS_WIDTH-1:0]  pc_e,
  output logic [ADDRESS_WIDTH-1:0]  pcplus4_e,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,

  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  // All stage fields live in one packed record. Flush and reset then clear
  // the stage with a single '0, and stall holds it with a single copy.
  typedef struct packed {
    logic                      valid;
    logic                      regwrite;
    logic [1:0]                resultsrc;
    logic                      memwrite;
    logic                      jump;
    logic                      branch;
    logic                      alusrc;
    logic [ALU_CTRL_WIDTH-1:0] alucontrol;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     immext;
    logic [ADDRESS_WIDTH-1:0]  pc;
    logic [ADDRESS_WIDTH-1:0]  pcplus4;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } stage_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  stage_t                stage_in;
  stage_t                stage_d,       stage_q;
  logic [CNT_WIDTH-1:0]  stall_count_d, stall_count_q;
  logic [CNT_WIDTH-1:0]  flush_count_d, flush_count_q;

  logic                  stall_hit;

  // An edge counts as a stall only when flush does not take priority.
  assign stall_hit = stall_e & ~flush_e;

  // ---------------------------------------------------------------------------
  // Incoming record for a normal load.
  //
  // When the decode slot is empty, every field that could change
  // architectural state, including rd_e, is squashed. A non-valid stage
  // therefore never writes the register file or memory, and it never appears
  // as a forwarding source. The data, PC and rs fields still pass through
  // unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_in.valid      = valid_d;
    stage_in.regwrite   = valid_d & regwrite_d;
    stage_in.resultsrc  = valid_d ? resultsrc_d : 2'b00;
    stage_in.memwrite   = valid_d & memwrite_d;
    stage_in.jump       = valid_d & jump_d;
    stage_in.branch     = valid_d & branch_d;
    stage_in.alusrc     = valid_d & alusrc_d;
    stage_in.alucontrol = valid_d ? alucontrol_d : '0;
    stage_in.rd1        = rd1_d;
    stage_in.rd2        = rd2_d;
    stage_in.immext     = immext_d;
    stage_in.pc         = pc_d;
    stage_in.pcplus4    = pcplus4_d;
    stage_in.rs1        = rs1_d;
    stage_in.rs2        = rs2_d;
    stage_in.rd         = valid_d ? rd_d : '0;
  end

  // ---------------------------------------------------------------------------
  // Next-state selection. Priority is flush > stall > load.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: next state defaults to current state first, so every path assigns
    // it and no latch can be inferred.
    stage_d = stage_q;
    if (flush_e) begin
      stage_d = '0;
    end else if (!stall_e) begin
      stage_d = stage_in;
    end
  end

  // Saturating counters. A clear overrides any increment in the same cycle.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (cnt_clr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_hit && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + 1'b1;
      end
      if (flush_e && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which keeps simulation order-independent and matches the hardware.
      stage_q       <= stage_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: driven only from flops, with no combinational path from *_d.
  // ---------------------------------------------------------------------------
  assign valid_e      = stage_q.valid;
  assign regwrite_e   = stage_q.regwrite;
  assign resultsrc_e  = stage_q.resultsrc;
  assign memwrite_e   = stage_q.memwrite;
  assign jump_e       = stage_q.jump;
  assign branch_e     = stage_q.branch;
  assign alusrc_e     = stage_q.alusrc;
  assign alucontrol_e = stage_q.alucontrol;
  assign rd1_e        = stage_q.rd1;
  assign rd2_e        = stage_q.rd2;
  assign immext_e     = stage_q.immext;
  assign pc_e         = stage_q.pc;
  assign pcplus4_e    = stage_q.pcplus4;
  assign rs1_e        = stage_q.rs1;
  assign rs2_e        = stage_q.rs2;
  assign rd_e         = stage_q.rd;

  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_decode_execute.sv
// -----------------------------------------------------------------------------
// tb_pipe_decode_execute
//
// Self-checking bench for pipe_decode_execute, built with CNT_WIDTH=4 so that
// counter saturation is reachable in a short run. A table of directed vectors
// covers load, stall, flush priority, invalid-decode squashing and counter
// clear. Hand-written sequences then cover the full field set, counter
// saturation, and asynchronous reset asserted in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_pipe_decode_execute;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_e, flush_e, cnt_clr;
  logic        valid_d, regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
  logic [1:0]  resultsrc_d;
  logic [3:0]  alucontrol_d;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d, pcplus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic        valid_e, regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
  logic [1:0]  resultsrc_e;
  logic [3:0]  alucontrol_e;
  logic [31:0] rd1_e, rd2_e, immext_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [CW-1:0] stall_count, flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_decode_execute #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .stall_e(stall_e), .flush_e(flush_e), .cnt_clr(cnt_clr),
    .valid_d(valid_d), .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d),
    .memwrite_d(memwrite_d), .jump_d(jump_d), .branch_d(branch_d),
    .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .valid_e(valid_e), .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e),
    .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
    .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One table entry: the inputs to drive before an edge, followed by the
  // expected stage outputs and counters after that edge.
  typedef struct {
    logic        stall, flush, clr, valid, regw, mem, jump;
    logic [3:0]  alu;
    logic [4:0]  rd, rs1;
    logic [31:0] rd1, pc;
    logic        e_valid, e_regw, e_mem, e_jump;
    logic [3:0]  e_alu;
    logic [4:0]  e_rd, e_rs1;
    logic [31:0] e_rd1, e_pc;
    logic [3:0]  e_sc, e_fc;
  } vec_t;

  function automatic vec_t mk(
    input logic s, f, c, v, rw, m, j, input logic [3:0] a, input logic [4:0] rd, rs1,
    input logic [31:0] d1, pc,
    input logic ev, erw, em, ej, input logic [3:0] ea, input logic [4:0] erd, ers1,
    input logic [31:0] ed1, epc, input logic [3:0] sc, fc);
    vec_t t;
    t.stall = s; t.flush = f; t.clr = c; t.valid = v; t.regw = rw; t.mem = m; t.jump = j;
    t.alu = a; t.rd = rd; t.rs1 = rs1; t.rd1 = d1; t.pc = pc;
    t.e_valid = ev; t.e_regw = erw; t.e_mem = em; t.e_jump = ej; t.e_alu = ea;
    t.e_rd = erd; t.e_rs1 = ers1; t.e_rd1 = ed1; t.e_pc = epc; t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction

  task automatic idle_inputs();
    stall_e = 0; flush_e = 0; cnt_clr = 0;
    valid_d = 0; regwrite_d = 0; memwrite_d = 0; jump_d = 0; branch_d = 0; alusrc_d = 0;
    resultsrc_d = 0; alucontrol_d = 0;
    rd1_d = 0; rd2_d = 0; immext_d = 0; pc_d = 0; pcplus4_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
  endtask

  // Drive a fully populated valid instruction.
  task automatic drive_full(input logic [31:0] base);
    valid_d = 1; regwrite_d = 1; memwrite_d = 1; jump_d = 1; branch_d = 1; alusrc_d = 1;
    resultsrc_d = 2'b10; alucontrol_d = 4'hC;
    rd1_d = base; rd2_d = base ^ 32'hFFFF_0000; immext_d = 32'hFFFF_F800;
    pc_d = 32'h0000_0400; pcplus4_d = 32'h0000_0404;
    rs1_d = 5'd3; rs2_d = 5'd4; rd_d = 5'd17;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    // Row order is: stall flush clr valid regw mem jump alu rd rs1 rd1 pc
    // followed by e_valid e_regw e_mem e_jump e_alu e_rd e_rs1 e_rd1 e_pc sc fc.
    vecs[0]  = mk(0,0,0, 1,1,0,0, 4'h3, 5'd5,  5'd2,  32'h1234_5678, 32'h100,
                  1,1,0,0, 4'h3, 5'd5,  5'd2,  32'h1234_5678, 32'h100,     0,0);
    vecs[1]  = mk(1,0,0, 1,0,1,1, 4'h9, 5'd6,  5'd8,  32'hAAAA_5555, 32'h104,
                  1,1,0,0, 4'h3, 5'd5,  5'd2,  32'h1234_5678, 32'h100,     1,0);
    vecs[2]  = mk(1,0,0, 1,0,1,1, 4'h9, 5'd6,  5'd8,  32'hAAAA_5555, 32'h104,
                  1,1,0,0, 4'h3, 5'd5,  5'd2,  32'h1234_5678, 32'h100,     2,0);
    vecs[3]  = mk(1,0,0, 1,0,1,1, 4'h9, 5'd6,  5'd8,  32'hAAAA_5555, 32'h104,
                  1,1,0,0, 4'h3, 5'd5,  5'd2,  32'h1234_5678, 32'h100,     3,0);
    vecs[4]  = mk(1,1,0, 1,1,1,1, 4'h9, 5'd6,  5'd8,  32'hAAAA_5555, 32'h104,
                  0,0,0,0, 4'h0, 5'd0,  5'd0,  32'h0,          32'h0,       3,1);
    vecs[5]  = mk(0,0,0, 0,1,1,1, 4'h7, 5'd7,  5'd9,  32'hCAFE_F00D, 32'h200,
                  0,0,0,0, 4'h0, 5'd0,  5'd9,  32'hCAFE_F00D, 32'h200,     3,1);
    vecs[6]  = mk(0,0,0, 1,0,1,1, 4'hA, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFC,
                  1,0,1,1, 4'hA, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 3,1);
    vecs[7]  = mk(1,0,0, 0,0,0,0, 4'h0, 5'd0,  5'd0,  32'h0,          32'h0,
                  1,0,1,1, 4'hA, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 4,1);
    vecs[8]  = mk(0,1,0, 1,1,1,1, 4'h5, 5'd12, 5'd13, 32'h5555_AAAA, 32'h300,
                  0,0,0,0, 4'h0, 5'd0,  5'd0,  32'h0,          32'h0,       4,2);
    vecs[9]  = mk(1,0,0, 1,1,0,0, 4'h5, 5'd12, 5'd13, 32'h5555_AAAA, 32'h300,
                  0,0,0,0, 4'h0, 5'd0,  5'd0,  32'h0,          32'h0,       5,2);
    vecs[10] = mk(0,0,1, 1,1,0,1, 4'h1, 5'd2,  5'd1,  32'h0000_0042, 32'h308,
                  1,1,0,1, 4'h1, 5'd2,  5'd1,  32'h0000_0042, 32'h308,     0,0);
    vecs[11] = mk(0,1,1, 1,1,1,1, 4'h2, 5'd3,  5'd4,  32'h0000_0099, 32'h30C,
                  0,0,0,0, 4'h0, 5'd0,  5'd0,  32'h0,          32'h0,       0,0);

    // Test 1: reset. First bring the DUT out of reset, load a non-zero stage,
    // then assert rst mid-cycle and confirm the outputs clear before any edge.
    idle_inputs();
    rst = 1;
    #12;
    @(negedge clk);
    rst = 0;
    drive_full(32'hDEAD_BEEF);
    stall_e = 1;  // one stall edge as well, so stall_count is non-zero
    edge_then_sample();
    check("pre_reset_stall_count", stall_count, 4'd1);
    @(negedge clk);
    stall_e = 0;
    edge_then_sample();
    check("pre_reset_rd1", rd1_e, 32'hDEAD_BEEF);
    #1 rst = 1;
    #1;
    check("async_reset_rd1",   rd1_e,   32'h0);
    check("async_reset_valid", valid_e, 1'b0);
    check("async_reset_pc",    pc_e,    32'h0);
    check("async_reset_rd",    rd_e,    5'd0);
    check("async_reset_scnt",  stall_count, 4'd0);
    check("async_reset_fcnt",  flush_count, 4'd0);
    edge_then_sample();
    check("reset_held_over_edge", rd1_e, 32'h0);
    @(negedge clk);
    rst = 0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_inputs();
      stall_e = vecs[i].stall; flush_e = vecs[i].flush; cnt_clr = vecs[i].clr;
      valid_d = vecs[i].valid; regwrite_d = vecs[i].regw; memwrite_d = vecs[i].mem;
      jump_d = vecs[i].jump; alucontrol_d = vecs[i].alu; rd_d = vecs[i].rd;
      rs1_d = vecs[i].rs1; rd1_d = vecs[i].rd1; pc_d = vecs[i].pc;
      edge_then_sample();
      check($sformatf("v%0d_valid", i), valid_e,      vecs[i].e_valid);
      check($sformatf("v%0d_regw",  i), regwrite_e,   vecs[i].e_regw);
      check($sformatf("v%0d_mem",   i), memwrite_e,   vecs[i].e_mem);
      check($sformatf("v%0d_jump",  i), jump_e,       vecs[i].e_jump);
      check($sformatf("v%0d_alu",   i), alucontrol_e, vecs[i].e_alu);
      check($sformatf("v%0d_rd",    i), rd_e,         vecs[i].e_rd);
      check($sformatf("v%0d_rs1",   i), rs1_e,        vecs[i].e_rs1);
      check($sformatf("v%0d_rd1",   i), rd1_e,        vecs[i].e_rd1);
      check($sformatf("v%0d_pc",    i), pc_e,         vecs[i].e_pc);
      check($sformatf("v%0d_scnt",  i), stall_count,  vecs[i].e_sc);
      check($sformatf("v%0d_fcnt",  i), flush_count,  vecs[i].e_fc);
    end

    // Full field set: load every field and check that no *_d value reaches
    // *_e before the edge.
    @(negedge clk);
    idle_inputs();
    drive_full(32'h0F0F_1234);
    #1;
    check("no_comb_path_rd1", rd1_e, 32'h0);
    check("no_comb_path_pc",  pc_e,  32'h0);
    edge_then_sample();
    check("full_valid",     valid_e,      1'b1);
    check("full_regw",      regwrite_e,   1'b1);
    check("full_mem",       memwrite_e,   1'b1);
    check("full_jump",      jump_e,       1'b1);
    check("full_branch",    branch_e,     1'b1);
    check("full_alusrc",    alusrc_e,     1'b1);
    check("full_resultsrc", resultsrc_e,  2'b10);
    check("full_alu",       alucontrol_e, 4'hC);
    check("full_rd1",       rd1_e,        32'h0F0F_1234);
    check("full_rd2",       rd2_e,        32'hF0F0_1234);
    check("full_imm",       immext_e,     32'hFFFF_F800);
    check("full_pc",        pc_e,         32'h0000_0400);
    check("full_pcplus4",   pcplus4_e,    32'h0000_0404);
    check("full_rs1",       rs1_e,        5'd3);
    check("full_rs2",       rs2_e,        5'd4);
    check("full_rd",        rd_e,         5'd17);

    // Invalid decode squashes every control field, but rs2/imm/pcplus4 pass.
    @(negedge clk);
    valid_d = 0;
    edge_then_sample();
    check("inv_branch",    branch_e,    1'b0);
    check("inv_alusrc",    alusrc_e,    1'b0);
    check("inv_resultsrc", resultsrc_e, 2'b00);
    check("inv_rs2",       rs2_e,       5'd4);
    check("inv_imm",       immext_e,    32'hFFFF_F800);
    check("inv_pcplus4",   pcplus4_e,   32'h0000_0404);

    // Flush clears the remaining data fields.
    @(negedge clk);
    valid_d = 1; flush_e = 1;
    edge_then_sample();
    check("flush_rd2",     rd2_e,       32'h0);
    check("flush_imm",     immext_e,    32'h0);
    check("flush_pcplus4", pcplus4_e,   32'h0);
    check("flush_rs2",     rs2_e,       5'd0);
    check("flush_branch",  branch_e,    1'b0);
    check("flush_resultsrc", resultsrc_e, 2'b00);

    // Saturation: clear, then stall for 20 edges with 4-bit counters.
    @(negedge clk);
    idle_inputs();
    cnt_clr = 1;
    edge_then_sample();
    check("sat_clear_scnt", stall_count, 4'd0);
    check("sat_clear_fcnt", flush_count, 4'd0);
    @(negedge clk);
    cnt_clr = 0; stall_e = 1;
    for (int i = 1; i <= 20; i++) begin
      edge_then_sample();
      if (i == 15) check("scnt_reaches_max", stall_count, 4'd15);
    end
    check("scnt_saturated", stall_count, 4'd15);
    @(negedge clk);
    flush_e = 1; stall_e = 0;
    for (int i = 0; i < 17; i++) edge_then_sample();
    check("fcnt_saturated",        flush_count, 4'd15);
    check("scnt_unchanged_by_flush", stall_count, 4'd15);
    @(negedge clk);
    flush_e = 0; stall_e = 1; cnt_clr = 1;
    edge_then_sample();
    check("clr_overrides_stall_scnt", stall_count, 4'd0);
    check("clr_fcnt",                 flush_count, 4'd0);

    // Reset asserted mid-stall. After release, the first edge applies the
    // stall selected by the inputs to the cleared stage, with no memory of
    // the earlier state.
    @(negedge clk);
    idle_inputs();
    drive_full(32'h7777_0001);
    edge_then_sample();
    check("pre_midreset_rd1", rd1_e, 32'h7777_0001);
    @(negedge clk);
    stall_e = 1;
    edge_then_sample();
    #2 rst = 1;
    #1;
    check("midstall_reset_rd1",  rd1_e,       32'h0);
    check("midstall_reset_regw", regwrite_e,  1'b0);
    check("midstall_reset_scnt", stall_count, 4'd0);
    @(negedge clk);
    rst = 0;
    edge_then_sample();
    check("post_reset_stall_holds_zero", rd1_e,       32'h0);
    check("post_reset_stall_valid",      valid_e,     1'b0);
    check("post_reset_stall_count",      stall_count, 4'd1);
    @(negedge clk);
    stall_e = 0;
    edge_then_sample();
    check("post_reset_load_rd1", rd1_e, 32'h7777_0001);
    check("post_reset_load_rd",  rd_e,  5'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the sequence above is bounded, so this fires only if time runs away.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
